// File: rtl/stoch_seq_pkg.sv
// ---------------------------------------------------------------------------
// stoch_seq_pkg
// Shared types and helpers for the stochastic matrix-multiply run controller.
//   seq_state_t : controller states (IDLE, CLEAR, RUN, DONE)
//   cnt_width() : bits needed to hold values 0..n. Used for the ones
//                 counters and for the run-window cycle counter.
// ---------------------------------------------------------------------------
package stoch_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } seq_state_t;

   // Width of a counter that must be able to reach the value n itself.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/stoch_ones_counter.sv
// ---------------------------------------------------------------------------
// stoch_ones_counter
// Counts the ones seen on one stochastic output bit. This count is the
// decoded value of that result element.
// Ports:
//   clock  : clock
//   clear  : synchronous clear. It has priority over counting.
//   enable : counting window qualifier
//   inc    : bitstream bit. It adds 1 when enable is high.
//   count  : accumulated ones count
// The caller sizes CNT_W so that the longest window cannot wrap the counter.
// ---------------------------------------------------------------------------
module stoch_ones_counter #(
   parameter int CNT_W = 9
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             enable,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // The counter clears first. Otherwise it adds the incoming bit, but only
   // inside the counting window. Outside the window it holds its value, so
   // the result stays readable until the next clear.
   always_ff @(posedge clock) begin
      if (clear) begin
         count <= '0;
      end else if (enable && inc) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/stoch_matmul_seq.sv
// ---------------------------------------------------------------------------
// stoch_matmul_seq
// Run controller for one stochastic matrix-multiply evaluation.
// Sequence: CLEAR holds the multiplier in reset for one cycle. RUN enables
// the bitstream generators for NUM_SAMPLES cycles. It counts ones on every
// Y[i][j] once the PIPE_LAT pipeline delay has passed. DONE presents the
// counts through a valid/ready handshake.
// Ports:
//   CLK, RST   : clock, synchronous active-high reset
//   start      : request an evaluation. Only looked at in IDLE.
//   busy       : high in CLEAR, RUN and DONE
//   mult_nrst  : active-low multiplier reset. Low during RST and CLEAR.
//   stream_en  : bitstream generator enable
//   Y          : multiplier output bits
//   res_valid  : result available (DONE)
//   res_ready  : consumer accepts the result
//   abort      : only with STOCH_MATMUL_SEQ_ABORT_EN. Cancels a run in
//                CLEAR or RUN.
//   counts     : ones count per result element
// Optional feature macro: STOCH_MATMUL_SEQ_ABORT_EN
// ---------------------------------------------------------------------------
module stoch_matmul_seq
   import stoch_seq_pkg::*;
#(
   parameter int NUM_ROWS    = 2,
   parameter int NUM_COLS    = 2,
   parameter int NUM_SAMPLES = 256,
   parameter int PIPE_LAT    = 1,
   parameter int CNT_W       = cnt_width(NUM_SAMPLES)
) (
   input  logic                                      CLK,
   input  logic                                      RST,
   input  logic                                      start,
   output logic                                      busy,
   output logic                                      mult_nrst,
   output logic                                      stream_en,
   input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]         Y,
   output logic                                      res_valid,
   input  logic                                      res_ready,
`ifdef STOCH_MATMUL_SEQ_ABORT_EN
   input  logic                                      abort,
`endif
   output logic [NUM_ROWS-1:0][NUM_COLS-1:0][CNT_W-1:0] counts
);

   localparam int CYC_W = cnt_width(NUM_SAMPLES + PIPE_LAT);
   localparam logic [CYC_W-1:0] LAST_CYC    = CYC_W'(NUM_SAMPLES + PIPE_LAT - 1);
   localparam logic [CYC_W-1:0] STREAM_END  = CYC_W'(NUM_SAMPLES);
   localparam logic [CYC_W-1:0] COUNT_START = CYC_W'(PIPE_LAT);

   seq_state_t       state;
   seq_state_t       nextState;
   logic [CYC_W-1:0] cycCnt;
   logic             abortHit;
   logic             countEn;
   logic             countClr;

   // An abort only matters while a run is being set up or streaming. In the
   // default build no abort port exists, so every accepted run completes.
`ifdef STOCH_MATMUL_SEQ_ABORT_EN
   assign abortHit = abort && ((state == CLEAR) || (state == RUN));
`else
   assign abortHit = 1'b0;
`endif

   // The multiplier reset is combinational. Because of that, it is already
   // held in reset during the RST cycle itself, before the state register
   // has returned to IDLE.
   assign mult_nrst = !(RST || (state == CLEAR));

   // The counters clear on reset, at the start of every run, and when a run
   // is aborted. An aborted run therefore never leaves a partial result.
   assign countClr = RST || (state == CLEAR) || abortHit;

   // State register. RST wins over everything, including a start in IDLE.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Run-window cycle counter. It restarts from zero in CLEAR and advances
   // once per RUN cycle. It is wide enough to hold NUM_SAMPLES+PIPE_LAT, so
   // the increment on the last RUN cycle does not wrap.
   always_ff @(posedge CLK) begin
      if (RST || (state == CLEAR)) begin
         cycCnt <= '0;
      end else if (state == RUN) begin
         cycCnt <= cycCnt + CYC_W'(1);
      end
   end

   // Next-state and output decode. The generators stream for the first
   // NUM_SAMPLES RUN cycles. Counting is delayed by PIPE_LAT cycles, so the
   // window lines up with the first valid Y bit. The last RUN cycle still
   // counts and then moves on to DONE.
   always_comb begin
      nextState = state;
      busy      = 1'b0;
      stream_en = 1'b0;
      res_valid = 1'b0;
      countEn   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               nextState = CLEAR;
            end
         end
         CLEAR: begin
            busy      = 1'b1;
            nextState = abortHit ? IDLE : RUN;
         end
         RUN: begin
            busy      = 1'b1;
            stream_en = (cycCnt < STREAM_END) && !abortHit;
            countEn   = (cycCnt >= COUNT_START) && !abortHit;
            if (abortHit) begin
               nextState = IDLE;
            end else if (cycCnt == LAST_CYC) begin
               nextState = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            res_valid = 1'b1;
            if (res_ready) begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // There is one ones counter per result element. They all share the
   // window and clear controls.
   for (genvar r = 0; r < NUM_ROWS; r++) begin : gRow
      for (genvar c = 0; c < NUM_COLS; c++) begin : gCol
         stoch_ones_counter #(
            .CNT_W (CNT_W)
         ) uCounter (
            .clock  (CLK),
            .clear  (countClr),
            .enable (countEn),
            .inc    (Y[r][c]),
            .count  (counts[r][c])
         );
      end
   end

endmodule

// File: tb/tb_stoch_matmul_seq.sv
// ---------------------------------------------------------------------------
// tb_stoch_matmul_seq
// Directed bench for stoch_matmul_seq with NUM_SAMPLES=16 and PIPE_LAT=1.
// Expected values are hand-derived from the run timing. The start edge is
// edge 0. CLEAR follows edge 0. RUN cyc=k follows edge k+1. DONE follows
// edge 18. The counting window covers cyc 1..16.
// Abort checks apply when STOCH_MATMUL_SEQ_ABORT_EN is defined.
// ---------------------------------------------------------------------------
module tb_stoch_matmul_seq;

   localparam int NR = 2;
   localparam int NC = 2;
   localparam int NS = 16;
   localparam int PL = 1;
   localparam int CW = 5;

   logic                           clk = 1'b0;
   logic                           rst;
   logic                           startIn;
   logic                           busyOut;
   logic                           multNrst;
   logic                           streamEn;
   logic [NR-1:0][NC-1:0]          yIn;
   logic                           resValid;
   logic                           resReady;
   logic                           abortIn;
   logic [NR-1:0][NC-1:0][CW-1:0]  countsOut;

   int checkCount = 0;
   int passCount  = 0;

   stoch_matmul_seq #(
      .NUM_ROWS    (NR),
      .NUM_COLS    (NC),
      .NUM_SAMPLES (NS),
      .PIPE_LAT    (PL)
   ) dut (
      .CLK       (clk),
      .RST       (rst),
      .start     (startIn),
      .busy      (busyOut),
      .mult_nrst (multNrst),
      .stream_en (streamEn),
      .Y         (yIn),
      .res_valid (resValid),
      .res_ready (resReady),
`ifdef STOCH_MATMUL_SEQ_ABORT_EN
      .abort     (abortIn),
`endif
      .counts    (countsOut)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Compares one observed value against its expected value and keeps the
   // pass and total counts.
   task automatic checkOutput(input string tag, input int actual, input int expected);
      checkCount++;
      if (actual == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Advances one clock. Inputs are driven, and outputs sampled, 1 ns after
   // the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Y pattern for the cycle that follows edge n of a run.
   //   mode 0: all ones
   //   mode 1: Y[0][0] toggles 1,0,.. from the first counting cycle (n=2).
   //           Y[1][1] is high only in CLEAR and RUN cyc 0.
   function automatic logic [NR-1:0][NC-1:0] yPattern(input int mode, input int n);
      logic [NR-1:0][NC-1:0] y;
      y = '0;
      if (mode == 0) begin
         y = '1;
      end else if (mode == 1) begin
         y[0][0] = (n >= 2) && (((n - 2) % 2) == 0);
         y[1][1] = (n <= 1);
      end
      return y;
   endfunction

   // Pulses start and then follows one run. It counts cycles with mult_nrst
   // low and with stream_en high, and notes the edge index at which
   // res_valid appears. If RST or abort is injected at edge index stopAt,
   // the signal is held across one edge and the task returns early.
   // validAt stays -1 if res_valid never appears within the budget.
   task automatic applyStimulus(input int mode, input int rstAt, input int abortAt,
                                output int nrstLow, output int streamHigh,
                                output int validAt, output bit stopped);
      nrstLow    = 0;
      streamHigh = 0;
      validAt    = -1;
      stopped    = 1'b0;
      startIn    = 1'b1;
      yIn        = '0;
      tick();
      startIn    = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if (!multNrst) nrstLow++;
         if (streamEn) streamHigh++;
         if (resValid) begin
            validAt = n;
            break;
         end
         yIn = yPattern(mode, n);
         if (n == rstAt || n == abortAt) begin
            if (n == rstAt) rst = 1'b1;
            if (n == abortAt) abortIn = 1'b1;
            tick();
            rst     = 1'b0;
            abortIn = 1'b0;
            stopped = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // Returns the sum of all counts. A cancelled run must leave this at zero.
   function automatic int countSum();
      int s;
      s = 0;
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            s += int'(countsOut[r][c]);
      return s;
   endfunction

   // After a cancelled run, watches long enough to cover a full run and
   // returns 1 if res_valid ever rose.
   task automatic watchNoValid(output bit seen);
      seen = 1'b0;
      for (int k = 0; k < 25; k++) begin
         if (resValid) seen = 1'b1;
         tick();
      end
   endtask

   initial begin
      int  nrstLow;
      int  streamHigh;
      int  validAt;
      bit  stopped;
      bit  seen;

      rst      = 1'b1;
      startIn  = 1'b1;
      resReady = 1'b1;
      abortIn  = 1'b0;
      yIn      = '0;

      // Reset held for 3 cycles with start high. RST must win.
      #1;
      checkOutput("rst_mult_nrst_pre", int'(multNrst), 0);
      tick(); tick(); tick();
      checkOutput("rst_busy", int'(busyOut), 0);
      checkOutput("rst_res_valid", int'(resValid), 0);
      checkOutput("rst_stream_en", int'(streamEn), 0);
      checkOutput("rst_mult_nrst", int'(multNrst), 0);
      checkOutput("rst_counts", countSum(), 0);
      rst     = 1'b0;
      startIn = 1'b0;
      tick(); tick();
      checkOutput("idle_busy", int'(busyOut), 0);
      checkOutput("idle_mult_nrst", int'(multNrst), 1);

      // Full run with all-ones Y.
      applyStimulus(0, -1, -1, nrstLow, streamHigh, validAt, stopped);
      checkOutput("full_nrst_low_cycles", nrstLow, 1);
      checkOutput("full_stream_cycles", streamHigh, NS);
      checkOutput("full_valid_edge", validAt, NS + PL + 1);
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            checkOutput($sformatf("full_count_%0d%0d", r, c), int'(countsOut[r][c]), 16);
      tick();
      checkOutput("full_idle_busy", int'(busyOut), 0);
      checkOutput("full_idle_valid", int'(resValid), 0);
      checkOutput("full_idle_count_held", int'(countsOut[0][0]), 16);

      // Pattern decode. Bits outside the window must be ignored.
      applyStimulus(1, -1, -1, nrstLow, streamHigh, validAt, stopped);
      checkOutput("pat_valid_edge", validAt, 18);
      checkOutput("pat_count_00", int'(countsOut[0][0]), 8);
      checkOutput("pat_count_01", int'(countsOut[0][1]), 0);
      checkOutput("pat_count_10", int'(countsOut[1][0]), 0);
      checkOutput("pat_count_11", int'(countsOut[1][1]), 0);
      tick();

      // Backpressure. DONE is held for 5 cycles while start and Y are noisy.
      resReady = 1'b0;
      applyStimulus(0, -1, -1, nrstLow, streamHigh, validAt, stopped);
      checkOutput("bp_valid_edge", validAt, 18);
      for (int k = 0; k < 5; k++) begin
         yIn     = NR*NC'($urandom);
         startIn = (k == 2);
         tick();
         checkOutput($sformatf("bp_valid_%0d", k), int'(resValid), 1);
         checkOutput($sformatf("bp_count00_%0d", k), int'(countsOut[0][0]), 16);
         checkOutput($sformatf("bp_count11_%0d", k), int'(countsOut[1][1]), 16);
      end
      startIn  = 1'b0;
      resReady = 1'b1;
      tick();
      checkOutput("bp_release_valid", int'(resValid), 0);
      checkOutput("bp_release_busy", int'(busyOut), 0);
      tick();
      checkOutput("bp_start_not_queued", int'(busyOut), 0);

      // Reset at RUN cyc=7, which follows edge 8.
      applyStimulus(0, 8, -1, nrstLow, streamHigh, validAt, stopped);
      checkOutput("mrst_reached", int'(stopped), 1);
      checkOutput("mrst_busy", int'(busyOut), 0);
      checkOutput("mrst_stream_en", int'(streamEn), 0);
      checkOutput("mrst_valid", int'(resValid), 0);
      checkOutput("mrst_counts", countSum(), 0);
      watchNoValid(seen);
      checkOutput("mrst_no_valid", int'(seen), 0);
      applyStimulus(0, -1, -1, nrstLow, streamHigh, validAt, stopped);
      checkOutput("mrst_rerun_valid_edge", validAt, 18);
      checkOutput("mrst_rerun_count", int'(countsOut[1][0]), 16);
      tick();

`ifdef STOCH_MATMUL_SEQ_ABORT_EN
      // Abort at RUN cyc=3, which follows edge 4.
      applyStimulus(0, -1, 4, nrstLow, streamHigh, validAt, stopped);
      checkOutput("abort_reached", int'(stopped), 1);
      checkOutput("abort_busy", int'(busyOut), 0);
      checkOutput("abort_stream_en", int'(streamEn), 0);
      checkOutput("abort_counts", countSum(), 0);
      watchNoValid(seen);
      checkOutput("abort_no_valid", int'(seen), 0);
`else
      // Without the abort port, driving abort has no effect and the run completes.
      applyStimulus(0, -1, 4, nrstLow, streamHigh, validAt, stopped);
      watchNoValid(seen);
      checkOutput("noabort_valid_seen", int'(seen), 1);
      checkOutput("noabort_count", int'(countsOut[0][1]), 16);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
